// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit.
//   state_t   : FSM encoding (IDLE while the pipe flows, MD_WAIT while a
//               multi-cycle mul/div holds S3).
//   NOP_INSTR : canonical NOP (addi x0,x0,0) that the pipeline registers load
//               when a bubble is requested.
package hazard_control_unit_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_control_unit_load_use.sv
// Load-use hazard detector (purely combinational).
//   mem_read_s3   : S3 instruction is a load
//   reg_w_addr_s3 : destination register of the S3 instruction
//   reg_addr1_s2  : rs1 of the S2 instruction
//   reg_addr2_s2  : rs2 of the S2 instruction
//   rs1_used_s2   : S2 instruction actually reads rs1
//   rs2_used_s2   : S2 instruction actually reads rs2
//   load_use      : S2 needs the loaded value before it exists
module load_use_detector (
  input  logic       mem_read_s3,
  input  logic [4:0] reg_w_addr_s3,
  input  logic [4:0] reg_addr1_s2,
  input  logic [4:0] reg_addr2_s2,
  input  logic       rs1_used_s2,
  input  logic       rs2_used_s2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // Only count a source field as a dependency when the instruction reads it;
  // unused fields often carry immediate bits that alias register numbers.
  assign rs1_hit = rs1_used_s2 && (reg_addr1_s2 == reg_w_addr_s3);
  assign rs2_hit = rs2_used_s2 && (reg_addr2_s2 == reg_w_addr_s3);

  // A load to x0 never produces a value anyone waits for.
  assign load_use = mem_read_s3 && (reg_w_addr_s3 != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit: stall, bubble and flush generation for a 5-stage pipe
// (S1 IF, S2 ID, S3 EX, S4 MEM, S5 WB; PR1..PR4 between stages).
//   CLK, RESET             : clock, asynchronous active-high reset
//   MEM_READ_S3, REG_W_ADDR_S3, REG_ADDR1_S2, REG_ADDR2_S2,
//   RS1_USED_S2, RS2_USED_S2 : fields for load-use detection
//   BJ_SIG                 : taken branch/jump resolved in S3
//   MULDIV_S3, MULDIV_DONE : multi-cycle mul/div handshake
//   STALL_PC/PR1/PR2       : hold PC / IF-ID / ID-EX
//   BUBBLE_PR2/PR3         : insert NOP into ID-EX / EX-MEM
//   FLUSH_PR1/PR2          : clear IF-ID / ID-EX
//   MULDIV_START           : one-cycle launch pulse for the mul/div unit
//   MD_ERR                 : one-cycle pulse when the mul/div watchdog aborts
//   STALL_COUNT            : saturating count of cycles with STALL_PC=1
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 8,
  parameter int PERF_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_READ_S3,
  input  logic [4:0]        REG_W_ADDR_S3,
  input  logic [4:0]        REG_ADDR1_S2,
  input  logic [4:0]        REG_ADDR2_S2,
  input  logic              RS1_USED_S2,
  input  logic              RS2_USED_S2,
  input  logic              BJ_SIG,
  input  logic              MULDIV_S3,
  input  logic              MULDIV_DONE,
  output logic              STALL_PC,
  output logic              STALL_PR1,
  output logic              STALL_PR2,
  output logic              BUBBLE_PR2,
  output logic              BUBBLE_PR3,
  output logic              FLUSH_PR1,
  output logic              FLUSH_PR2,
  output logic              MULDIV_START,
  output logic              MD_ERR,
  output logic [PERF_W-1:0] STALL_COUNT
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MD_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             load_use;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  load_use_detector u_load_use (
    .mem_read_s3   (MEM_READ_S3),
    .reg_w_addr_s3 (REG_W_ADDR_S3),
    .reg_addr1_s2  (REG_ADDR1_S2),
    .reg_addr2_s2  (REG_ADDR2_S2),
    .rs1_used_s2   (RS1_USED_S2),
    .rs2_used_s2   (RS2_USED_S2),
    .load_use      (load_use)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      STALL_COUNT <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (STALL_PC) STALL_COUNT <= sat_inc(STALL_COUNT);
    end
  end

  // Outputs are forced low while RESET is held so nothing leaks from live inputs.
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    STALL_PC     = 1'b0;
    STALL_PR1    = 1'b0;
    STALL_PR2    = 1'b0;
    BUBBLE_PR2   = 1'b0;
    BUBBLE_PR3   = 1'b0;
    FLUSH_PR1    = 1'b0;
    FLUSH_PR2    = 1'b0;
    MULDIV_START = 1'b0;
    MD_ERR       = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE: begin
          if (BJ_SIG) begin
            // S2 holds a wrong-path instruction, so any load-use there is moot.
            FLUSH_PR1 = 1'b1;
            FLUSH_PR2 = 1'b1;
          end else if (MULDIV_S3) begin
            MULDIV_START = 1'b1;
            if (!MULDIV_DONE) begin
              STALL_PC   = 1'b1;
              STALL_PR1  = 1'b1;
              STALL_PR2  = 1'b1;
              BUBBLE_PR3 = 1'b1;
              state_d    = MD_WAIT;
              wd_d       = CNT_W'(1);
            end
          end else if (load_use) begin
            // One bubble is enough: the load reaches S4 and forwarding covers it.
            STALL_PC   = 1'b1;
            STALL_PR1  = 1'b1;
            BUBBLE_PR2 = 1'b1;
          end
        end
        MD_WAIT: begin
          if (MULDIV_DONE) begin
            state_d = IDLE;
          end else if (wd_q == WD_LIMIT) begin
            MD_ERR  = 1'b1;
            state_d = IDLE;
          end else begin
            STALL_PC   = 1'b1;
            STALL_PR1  = 1'b1;
            STALL_PR2  = 1'b1;
            BUBBLE_PR3 = 1'b1;
            wd_d       = wd_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A branch and a mul/div can never occupy S3 together.
  assert property (@(posedge CLK) disable iff (RESET) !(BJ_SIG && MULDIV_S3));

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  // Output vector layout: {STALL_PC, STALL_PR1, STALL_PR2, BUBBLE_PR2,
  //                        BUBBLE_PR3, FLUSH_PR1, FLUSH_PR2, MULDIV_START, MD_ERR}
  localparam logic [8:0] E_NONE  = 9'h000;
  localparam logic [8:0] E_LU    = 9'h1A0;
  localparam logic [8:0] E_MDGO  = 9'h1D2;
  localparam logic [8:0] E_MDW   = 9'h1D0;
  localparam logic [8:0] E_FLUSH = 9'h00C;
  localparam logic [8:0] E_START = 9'h002;
  localparam logic [8:0] E_ERR   = 9'h001;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, rs1_used, rs2_used, bj, mul, done;
  logic [4:0] w_addr, a1, a2;
  logic wd_mul, wd_done;

  logic s_pc, s_pr1, s_pr2, b_pr2, b_pr3, f_pr1, f_pr2, m_start, m_err;
  logic [31:0] cnt;
  logic w_pc, w_pr1, w_pr2, wb_pr2, wb_pr3, wf_pr1, wf_pr2, w_start, w_err;
  logic [1:0] w_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_wd_q[$];

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .CLK(clk), .RESET(rst),
    .MEM_READ_S3(mem_read), .REG_W_ADDR_S3(w_addr),
    .REG_ADDR1_S2(a1), .REG_ADDR2_S2(a2),
    .RS1_USED_S2(rs1_used), .RS2_USED_S2(rs2_used),
    .BJ_SIG(bj), .MULDIV_S3(mul), .MULDIV_DONE(done),
    .STALL_PC(s_pc), .STALL_PR1(s_pr1), .STALL_PR2(s_pr2),
    .BUBBLE_PR2(b_pr2), .BUBBLE_PR3(b_pr3),
    .FLUSH_PR1(f_pr1), .FLUSH_PR2(f_pr2),
    .MULDIV_START(m_start), .MD_ERR(m_err), .STALL_COUNT(cnt)
  );

  hazard_control_unit #(.MD_TIMEOUT(4), .CNT_W(8), .PERF_W(2)) dut_wd (
    .CLK(clk), .RESET(rst),
    .MEM_READ_S3(1'b0), .REG_W_ADDR_S3(5'd0),
    .REG_ADDR1_S2(5'd0), .REG_ADDR2_S2(5'd0),
    .RS1_USED_S2(1'b0), .RS2_USED_S2(1'b0),
    .BJ_SIG(1'b0), .MULDIV_S3(wd_mul), .MULDIV_DONE(wd_done),
    .STALL_PC(w_pc), .STALL_PR1(w_pr1), .STALL_PR2(w_pr2),
    .BUBBLE_PR2(wb_pr2), .BUBBLE_PR3(wb_pr3),
    .FLUSH_PR1(wf_pr1), .FLUSH_PR2(wf_pr2),
    .MULDIV_START(w_start), .MD_ERR(w_err), .STALL_COUNT(w_cnt)
  );

  function automatic logic [8:0] outs();
    return {s_pc, s_pr1, s_pr2, b_pr2, b_pr3, f_pr1, f_pr2, m_start, m_err};
  endfunction

  function automatic logic [8:0] outs_wd();
    return {w_pc, w_pr1, w_pr2, wb_pr2, wb_pr3, wf_pr1, wf_pr2, w_start, w_err};
  endfunction

  task automatic clear_inputs();
    mem_read = 0; rs1_used = 0; rs2_used = 0; bj = 0; mul = 0; done = 0;
    w_addr = 0; a1 = 0; a2 = 0; wd_mul = 0; wd_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Drive at #1 after a rising edge so values settle before the next sample.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    clear_inputs();
    rst = 1;
    // Hazard-producing inputs must not reach the outputs while in reset.
    mem_read = 1; w_addr = 5; a1 = 5; rs1_used = 1; wd_mul = 1;
    exp_q.push_back(E_NONE);
    exp_wd_q.push_back(E_NONE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_outs got %h want %h", outs(), e); end
    e = exp_wd_q.pop_front(); checks++;
    if (outs_wd() !== e) begin errors++; $display("FAIL reset_outs_wd got %h want %h", outs_wd(), e); end
    checks++;
    if (cnt !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
    checks++;
    if (w_cnt !== 2'd0) begin errors++; $display("FAIL reset_count_wd got %0d want 0", w_cnt); end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    do_reset();
    // lw x5 in S3, add x6,x5,x7 in S2
    next_cycle();
    mem_read = 1; w_addr = 5; a1 = 5; a2 = 7; rs1_used = 1; rs2_used = 1;
    exp_q.push_back(E_LU);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL load_use got %h want %h", outs(), e); end
    // Load moved to S4: no hazard left.
    next_cycle();
    clear_inputs();
    exp_q.push_back(E_NONE);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL load_use_after got %h want %h", outs(), e); end
    checks++;
    if (cnt !== 32'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", cnt); end
    // Load to x0, S2 reads x0.
    next_cycle();
    mem_read = 1; w_addr = 0; a1 = 0; rs1_used = 1;
    exp_q.push_back(E_NONE);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL load_x0 got %h want %h", outs(), e); end
    // Load to x5, rs2 field is 5 but unused.
    next_cycle();
    clear_inputs();
    mem_read = 1; w_addr = 5; a1 = 3; a2 = 5; rs1_used = 1; rs2_used = 0;
    exp_q.push_back(E_NONE);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL rs2_unused got %h want %h", outs(), e); end
    // Same fields with rs2 used: hazard via rs2.
    next_cycle();
    rs2_used = 1;
    exp_q.push_back(E_LU);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL rs2_used got %h want %h", outs(), e); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_muldiv_long();
    logic [8:0] e;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c <= 34; c++) begin
      next_cycle();
      mul  = (c <= 33);
      done = (c == 33);
      exp_q.push_back(c == 0 ? E_MDGO : (c <= 32 ? E_MDW : E_NONE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs() !== e) begin
        errors++; bad++;
        if (bad <= 5) $display("FAIL muldiv_cycle%0d got %h want %h", c, outs(), e);
      end
    end
    checks++;
    if (cnt !== 32'd33) begin errors++; $display("FAIL muldiv_count got %0d want 33", cnt); end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    logic [8:0] e;
    do_reset();
    for (int run = 0; run < 2; run++) begin
      for (int c = 0; c <= 5; c++) begin
        next_cycle();
        wd_mul  = (c <= 4);
        wd_done = (run == 1) && (c == 4);
        if (c == 0)      exp_wd_q.push_back(E_MDGO);
        else if (c <= 3) exp_wd_q.push_back(E_MDW);
        else if (c == 4) exp_wd_q.push_back(run == 0 ? E_ERR : E_NONE);
        else             exp_wd_q.push_back(E_NONE);
        @(negedge clk);
        e = exp_wd_q.pop_front(); checks++;
        if (outs_wd() !== e) begin
          errors++; $display("FAIL watchdog_run%0d_cycle%0d got %h want %h", run, c, outs_wd(), e);
        end
      end
      // Four stall cycles per run against a 2-bit counter: pinned at 3.
      checks++;
      if (w_cnt !== 2'd3) begin errors++; $display("FAIL watchdog_count_sat run%0d got %0d want 3", run, w_cnt); end
    end
    clear_inputs();
  endtask

  task automatic test_branch_fast_mul();
    logic [8:0] e;
    do_reset();
    next_cycle();
    bj = 1; mem_read = 1; w_addr = 9; a1 = 9; rs1_used = 1;
    exp_q.push_back(E_FLUSH);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL branch_over_load got %h want %h", outs(), e); end
    next_cycle();
    clear_inputs();
    mul = 1; done = 1;
    exp_q.push_back(E_START);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL fast_mul got %h want %h", outs(), e); end
    // Still IDLE after the fast mul: a load-use is honoured right away.
    next_cycle();
    clear_inputs();
    mem_read = 1; w_addr = 4; a1 = 4; rs1_used = 1;
    exp_q.push_back(E_LU);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL after_fast_mul got %h want %h", outs(), e); end
    checks++;
    if (cnt !== 32'd0) begin errors++; $display("FAIL branch_count got %0d want 0", cnt); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_in_md_wait();
    logic [8:0] e;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      next_cycle();
      mul = 1;
      exp_q.push_back(c == 0 ? E_MDGO : E_MDW);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL md_wait_cycle%0d got %h want %h", c, outs(), e); end
    end
    // Third MD_WAIT cycle, mid-cycle reset.
    rst = 1;
    exp_q.push_back(E_NONE);
    #1;
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_mid_wait got %h want %h", outs(), e); end
    checks++;
    if (cnt !== 32'd0) begin errors++; $display("FAIL reset_mid_count got %0d want 0", cnt); end
    #1;
    rst = 0;
    exp_q.push_back(E_MDGO);
    #1;
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL relaunch got %h want %h", outs(), e); end
    // Finish the relaunched op cleanly.
    next_cycle();
    done = 1;
    exp_q.push_back(E_NONE);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL relaunch_done got %h want %h", outs(), e); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_muldiv_long();
    test_watchdog();
    test_branch_fast_mul();
    test_reset_in_md_wait();
    checks++;
    if (exp_q.size() != 0 || exp_wd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d left want 0/0", exp_q.size(), exp_wd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
